// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered read data, fill count and threshold flags.
// Optional sticky overflow/underflow flags with clear_err when PARAM_SYNC_FIFO_ERR_EN is defined.
module param_sync_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write_en,
    input  logic                       read_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      out,
    output logic                       mem_full,
    output logic                       mem_empty,
    output logic                       almost_full,
    output logic                       almost_empty,
`ifdef PARAM_SYNC_FIFO_ERR_EN
    input  logic                       clear_err,
    output logic                       overflow,
    output logic                       underflow,
`endif
    output logic [$clog2(DEPTH):0]     fill_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Acceptance looks only at registered flags, so full+both reads and empty+both writes.
    assign w_wr_acc = write_en && !mem_full;
    assign w_rd_acc = read_en  && !mem_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_out    <= '0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_out    <= r_mem[r_rd_ptr];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= data_in;
    end

    assign out          = r_out;
    assign fill_count   = r_count;
    assign mem_full     = (int'(r_count) == DEPTH);
    assign mem_empty    = (r_count == '0);
    assign almost_full  = (int'(r_count) >= AFULL_THRESH);
    assign almost_empty = (int'(r_count) <= AEMPTY_THRESH);

`ifdef PARAM_SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Set has priority over clear_err in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write_en && mem_full)
                r_overflow <= 1'b1;
            else if (clear_err)
                r_overflow <= 1'b0;
            if (read_en && mem_empty)
                r_underflow <= 1'b1;
            else if (clear_err)
                r_underflow <= 1'b0;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
